// File: rtl/fsm_seq_arbiter.sv
// Round-robin arbiter that lends one shared 2-bit-input FSM to three requesters.
// Each grant runs FLUSH -> DRIVE (max(hold,1) cycles) -> RELEASE. All outputs are registered.
module fsm_seq_arbiter #(
  parameter int HOLD_W = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [2:0]          req,
  input  logic [5:0]          sym,
  input  logic [3*HOLD_W-1:0] hold,
  output logic [2:0]          gnt,
  output logic [2:0]          done,
  output logic [1:0]          fsm_in,
  output logic                fsm_clr,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRIVE, RELEASE} state_t;

  state_t            state_q;
  logic [2:0]        gnt_q, done_q;
  logic [1:0]        fsm_in_q;
  logic              fsm_clr_q, busy_q;
  logic [1:0]        win_q, last_q;
  logic [1:0]        sym_q;
  logic [HOLD_W-1:0] hold_q, cnt_q;

  logic [1:0]        p0, p1, p2, win_d;
  logic [1:0]        sym_d;
  logic [HOLD_W-1:0] hold_d;

  // Search order starts just after the last winner.
  always_comb begin
    case (last_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (req[p0])      win_d = p0;
    else if (req[p1]) win_d = p1;
    else              win_d = p2;
  end

  always_comb begin
    case (win_d)
      2'd1:    begin sym_d = sym[3:2]; hold_d = hold[2*HOLD_W-1:HOLD_W];   end
      2'd2:    begin sym_d = sym[5:4]; hold_d = hold[3*HOLD_W-1:2*HOLD_W]; end
      default: begin sym_d = sym[1:0]; hold_d = hold[HOLD_W-1:0];          end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      done_q    <= 3'b000;
      fsm_in_q  <= 2'd0;
      fsm_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      win_q     <= 2'd0;
      last_q    <= 2'd2;
      sym_q     <= 2'd0;
      hold_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != 3'b000) begin
            state_q   <= FLUSH;
            gnt_q     <= 3'b001 << win_d;
            win_q     <= win_d;
            sym_q     <= sym_d;
            hold_q    <= hold_d;
            fsm_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        FLUSH: begin
          fsm_clr_q <= 1'b0;
          if (!req[win_q]) begin
            state_q <= RELEASE;
            gnt_q   <= 3'b000;
            last_q  <= win_q;
          end else begin
            state_q  <= DRIVE;
            fsm_in_q <= sym_q;
            cnt_q    <= (hold_q == '0) ? HOLD_W'(1) : hold_q;
          end
        end
        DRIVE: begin
          // A dropped request wins over normal expiry: abort reports no done.
          if (!req[win_q] || cnt_q == HOLD_W'(1)) begin
            state_q  <= RELEASE;
            gnt_q    <= 3'b000;
            fsm_in_q <= 2'd0;
            last_q   <= win_q;
            done_q   <= req[win_q] ? (3'b001 << win_q) : 3'b000;
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 3'b000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign fsm_in  = fsm_in_q;
  assign fsm_clr = fsm_clr_q;
  assign busy    = busy_q;

endmodule

// File: doc/fsm_seq_arbiter.md
FSM_SEQ_ARBITER -- requirements
Module: fsm_seq_arbiter

Interface
REQ-001 Parameter: HOLD_W, default 4, width of each requester's hold-length field.
REQ-002 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  3  request lines, requester i on bit i.
REQ-005 Port: sym  input  6  requested 2-bit symbol per requester; requester i uses bits [2i+1:2i].
REQ-006 Port: hold  input  3*HOLD_W  cycles to drive the symbol per requester; requester i uses bits [HOLD_W*(i+1)-1:HOLD_W*i].
REQ-007 Port: gnt  output  3  one-hot grant, or all zero.
REQ-008 Port: done  output  3  one-cycle completion pulse on the bit of the finished requester.
REQ-009 Port: fsm_in  output  2  symbol driven to the shared FSM input.
REQ-010 Port: fsm_clr  output  1  synchronous clear pulse to the shared FSM.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL share one 2-bit-input FSM among 3 requesters, granting exactly one at a time.
REQ-013 All outputs SHALL be registered; there is no combinational path from inputs to outputs.
REQ-014 States SHALL be IDLE, FLUSH, DRIVE and RELEASE.
REQ-015 IDLE SHALL go to FLUSH on the edge where req != 0, and otherwise stay in IDLE.
REQ-016 On that edge the block SHALL set gnt to the winner's one-hot code, latch the winner's sym and hold into internal registers, and set fsm_clr=1.
REQ-017 Arbitration SHALL be round-robin: search order starts at (last_winner+1) mod 3; last_winner resets to 2, so requester 0 has first priority after reset.
REQ-018 FLUSH SHALL last exactly one cycle and then go to DRIVE, with fsm_clr=0, fsm_in=latched sym, and the down-counter loaded with the latched hold.
REQ-019 A latched hold of 0 SHALL be treated as 1; DRIVE SHALL last exactly max(hold,1) cycles.
REQ-020 Changes on sym/hold after the grant edge SHALL NOT affect the current transaction.
REQ-021 When the counter expires in DRIVE, the block SHALL go to RELEASE with fsm_in=0, gnt=0, done=one-hot of the winner, and last_winner updated.
REQ-022 Abort: if the granted requester's req bit is low in DRIVE (or in FLUSH), the next state SHALL be RELEASE with done=0; last_winner is still updated.
REQ-023 RELEASE SHALL last exactly one cycle, clear done, and then go to IDLE unconditionally.
REQ-024 Grant-to-first-symbol latency SHALL be 2 edges (IDLE->FLUSH->DRIVE).
REQ-025 Minimum spacing between consecutive grants SHALL be hold+3 cycles.
REQ-026 A new req arriving on the same edge as a RELEASE->IDLE transition SHALL first be seen in IDLE on the following edge.
REQ-027 Requests from non-granted requesters during a transaction SHALL be ignored, not queued, until IDLE.
REQ-028 fsm_in SHALL be 0 in every state except DRIVE.
REQ-029 gnt SHALL be nonzero only in FLUSH and DRIVE.
REQ-030 fsm_clr SHALL be high only in FLUSH.

Reset
REQ-031 While clr=1, the block SHALL immediately, without waiting for a clk edge, force the state to IDLE and set gnt=0, done=0, fsm_in=0, fsm_clr=0, busy=0, counter=0 and last_winner=2.
REQ-032 Assertion of clr mid-transaction SHALL abandon the transaction with no done pulse.
REQ-033 After clr deasserts, operation SHALL resume on the first clk rising edge.

Verification
REQ-034 Single request: req=001, sym[1:0]=2, hold0=3 -> fsm_clr high 1 cycle, fsm_in=2 for exactly 3 cycles, done=001 for 1 cycle, busy low after RELEASE.
REQ-035 Round-robin: req=111 held, each hold=1 -> grant order 001, 010, 100, 001; each grant 4 cycles apart.
REQ-036 Hold zero: req=010, hold1=0 -> DRIVE lasts exactly 1 cycle, done=010.
REQ-037 Abort: req=100, hold2=8, req drops on the 3rd DRIVE cycle -> RELEASE with done=000; next req=111 is granted to 001.
REQ-038 Latch check: sym0 is changed from 1 to 3 during DRIVE -> fsm_in stays 1 for the full hold.
REQ-039 Async reset: clr is pulsed between clock edges mid-DRIVE -> all outputs are 0 before the next edge, state is IDLE, and requester 0 wins the next req=111.
